// File: rtl/alu_op_driver.sv
// alu_op_driver: registers one command onto a fixed-latency ALU, waits LATENCY cycles,
// captures the result and holds it until the consumer takes it.
module alu_op_driver #(
   parameter int WIDTH   = 16,
   parameter int LATENCY = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [1:0]       cmd_op,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [1:0]       alu_op,
   input  logic [WIDTH-1:0] alu_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_y,
   output logic [1:0]       rsp_op,
   output logic             rsp_zero,
   output logic             busy,
   output logic [15:0]      op_count
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [3:0] LAT = 4'(LATENCY);
   state_t     state;
   logic [3:0] cnt;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         cmd_ready <= 1'b0;
         busy      <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
         rsp_valid <= 1'b0;
         rsp_y     <= '0;
         rsp_op    <= '0;
         rsp_zero  <= 1'b0;
         op_count  <= '0;
      end else
         case (state)
            IDLE:
               // cmd_ready is low for the first edge after reset, so acceptance waits for it
               if (cmd_ready && cmd_valid) begin
                  alu_a     <= cmd_a;
                  alu_b     <= cmd_b;
                  alu_op    <= cmd_op;
                  cnt       <= LAT;
                  state     <= WAIT;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
               end else
                  cmd_ready <= 1'b1;
            WAIT:
               if (cnt != 4'd0)
                  cnt <= cnt - 4'd1;
               else begin
                  rsp_y     <= alu_y;
                  rsp_op    <= alu_op;
                  rsp_zero  <= (alu_y == '0);
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            RESP:
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  busy      <= 1'b0;
                  cmd_ready <= 1'b1;
                  op_count  <= op_count + 16'd1;
                  state     <= IDLE;
               end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_alu_op_driver.sv
// tb_alu_op_driver: directed checks of alu_op_driver at LATENCY 1 (main), 0 and 15.
module tb_alu_op_driver;
   logic        clk = 1'b0, reset = 1'b0;
   logic        cmd_valid = 1'b0, lv = 1'b0, rsp_ready = 1'b0, lr = 1'b0;
   logic [15:0] cmd_a = '0, cmd_b = '0;
   logic [1:0]  cmd_op = '0;
   logic [15:0] cyc = '0;
   int          total = 0, bad = 0;

   logic        cmd_ready, rsp_valid, rsp_zero, busy;
   logic [15:0] alu_a, alu_b, alu_y, rsp_y, op_count;
   logic [1:0]  alu_op, rsp_op;
   logic        cmd_ready0, rsp_valid0, rsp_zero0, busy0;
   logic [15:0] alu_a0, alu_b0, rsp_y0, op_count0;
   logic [1:0]  alu_op0, rsp_op0;
   logic        cmd_ready15, rsp_valid15, rsp_zero15, busy15;
   logic [15:0] alu_a15, alu_b15, rsp_y15, op_count15;
   logic [1:0]  alu_op15, rsp_op15;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 16'd1;

   // ALU model for the main instance
   always_comb
      case (alu_op)
         2'b00:   alu_y = alu_a + alu_b;
         2'b01:   alu_y = alu_a - alu_b;
         2'b10:   alu_y = alu_a & alu_b;
         default: alu_y = alu_a | alu_b;
      endcase

   alu_op_driver #(.WIDTH(16), .LATENCY(1)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_y(alu_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_y(rsp_y), .rsp_op(rsp_op), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count));

   // Latency instances see a result that changes every cycle
   alu_op_driver #(.WIDTH(16), .LATENCY(0)) dut0 (
      .clk(clk), .reset(reset), .cmd_valid(lv), .cmd_ready(cmd_ready0),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .alu_a(alu_a0), .alu_b(alu_b0),
      .alu_op(alu_op0), .alu_y(cyc), .rsp_valid(rsp_valid0), .rsp_ready(lr),
      .rsp_y(rsp_y0), .rsp_op(rsp_op0), .rsp_zero(rsp_zero0), .busy(busy0), .op_count(op_count0));

   alu_op_driver #(.WIDTH(16), .LATENCY(15)) dut15 (
      .clk(clk), .reset(reset), .cmd_valid(lv), .cmd_ready(cmd_ready15),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .alu_a(alu_a15), .alu_b(alu_b15),
      .alu_op(alu_op15), .alu_y(cyc), .rsp_valid(rsp_valid15), .rsp_ready(lr),
      .rsp_y(rsp_y15), .rsp_op(rsp_op15), .rsp_zero(rsp_zero15), .busy(busy15), .op_count(op_count15));

   task automatic test_reset();
      #3;
      total++;
      if ({cmd_ready, busy, rsp_valid, rsp_zero, alu_a, alu_b, alu_op, rsp_y, rsp_op, op_count} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got ready=%b busy=%b valid=%b y=%h cnt=%h want all zero",
                  cmd_ready, busy, rsp_valid, rsp_y, op_count);
      end
      repeat (2) @(negedge clk);
      total++;
      if ({cmd_ready, cmd_ready0, cmd_ready15, busy} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_held_ready got %b%b%b busy=%b want 0000", cmd_ready, cmd_ready0, cmd_ready15, busy);
      end
      reset = 1'b1;
      #1;
      total++;
      if (cmd_ready !== 1'b0) begin
         bad++;
         $display("FAIL release_ready_before_edge got %b want 0", cmd_ready);
      end
      @(negedge clk);
      total++;
      if ({cmd_ready, busy, cmd_ready0, cmd_ready15} !== 4'b1011) begin
         bad++;
         $display("FAIL release_ready_after_edge got %b%b%b%b want 1011", cmd_ready, busy, cmd_ready0, cmd_ready15);
      end
   endtask

   task automatic test_basic();
      cmd_a = 16'h0003; cmd_b = 16'h0005; cmd_op = 2'b00; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      total++;
      if ({busy, cmd_ready, rsp_valid, alu_a, alu_b, alu_op} !== {3'b100, 16'h0003, 16'h0005, 2'b00}) begin
         bad++;
         $display("FAIL basic_accept got busy=%b ready=%b valid=%b a=%h b=%h op=%b want 1 0 0 0003 0005 00",
                  busy, cmd_ready, rsp_valid, alu_a, alu_b, alu_op);
      end
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL basic_early_valid got %b want 0", rsp_valid);
      end
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_y, rsp_op, rsp_zero, op_count} !== {1'b1, 16'h0008, 2'b00, 1'b0, 16'h0000}) begin
         bad++;
         $display("FAIL basic_resp got valid=%b y=%h op=%b zero=%b cnt=%h want 1 0008 00 0 0000",
                  rsp_valid, rsp_y, rsp_op, rsp_zero, op_count);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      total++;
      if ({rsp_valid, cmd_ready, busy, op_count, rsp_y} !== {3'b010, 16'h0001, 16'h0008}) begin
         bad++;
         $display("FAIL basic_handshake got valid=%b ready=%b busy=%b cnt=%h y=%h want 0 1 0 0001 0008",
                  rsp_valid, cmd_ready, busy, op_count, rsp_y);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      total++;
      if ({op_count, rsp_valid} !== {16'h0001, 1'b0}) begin
         bad++;
         $display("FAIL idle_ready_pulse got cnt=%h valid=%b want 0001 0", op_count, rsp_valid);
      end
   endtask

   task automatic test_backpressure();
      bit seen = 0;
      cmd_a = 16'h0007; cmd_b = 16'h0002; cmd_op = 2'b00; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         seen = rsp_valid;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL bp_wait_valid got no rsp_valid want 1 within 10 cycles");
      end
      cmd_valid = 1'b1; cmd_a = 16'h1111; cmd_b = 16'h2222; cmd_op = 2'b11;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         total++;
         if ({rsp_valid, rsp_y, rsp_op, alu_a, op_count, cmd_ready} !== {1'b1, 16'h0009, 2'b00, 16'h0007, 16'h0001, 1'b0}) begin
            bad++;
            $display("FAIL bp_hold[%0d] got valid=%b y=%h op=%b a=%h cnt=%h ready=%b want 1 0009 00 0007 0001 0",
                     k, rsp_valid, rsp_y, rsp_op, alu_a, op_count, cmd_ready);
         end
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      total++;
      if ({op_count, rsp_valid, cmd_ready, alu_a} !== {16'h0002, 2'b01, 16'h0007}) begin
         bad++;
         $display("FAIL bp_release got cnt=%h valid=%b ready=%b a=%h want 0002 0 1 0007",
                  op_count, rsp_valid, cmd_ready, alu_a);
      end
   endtask

   task automatic test_zero_opcodes();
      int          acc[2];
      int          na = 0, nr = 0;
      logic [1:0]  rop[2];
      logic [15:0] ry[2];
      cmd_a = 16'h0005; cmd_b = 16'h0005; cmd_op = 2'b01; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({rsp_valid, rsp_y, rsp_op, rsp_zero} !== {1'b1, 16'h0000, 2'b01, 1'b1}) begin
         bad++;
         $display("FAIL zero_resp got valid=%b y=%h op=%b zero=%b want 1 0000 01 1", rsp_valid, rsp_y, rsp_op, rsp_zero);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      cmd_a = 16'h00F0; cmd_b = 16'h0F3C; cmd_op = 2'b10; cmd_valid = 1'b1;
      for (int k = 0; k < 20 && nr < 2; k++) begin
         if (na == 1) begin cmd_op = 2'b11; cmd_b = 16'h0F0F; end
         if (na == 2) cmd_valid = 1'b0;
         if (cmd_ready && cmd_valid && na < 2) begin acc[na] = k; na++; end
         if (rsp_valid && nr < 2) begin rop[nr] = rsp_op; ry[nr] = rsp_y; nr++; end
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      cmd_valid = 1'b0;
      total++;
      if (na != 2 || nr != 2) begin
         bad++;
         $display("FAIL b2b_counts got acc=%0d rsp=%0d want 2 2", na, nr);
      end else begin
         total++;
         if (acc[1] - acc[0] != 4) begin
            bad++;
            $display("FAIL b2b_spacing got %0d want 4", acc[1] - acc[0]);
         end
         total++;
         if ({rop[0], ry[0], rop[1], ry[1]} !== {2'b10, 16'h0030, 2'b11, 16'h0FFF}) begin
            bad++;
            $display("FAIL b2b_results got %b/%h %b/%h want 10/0030 11/0fff", rop[0], ry[0], rop[1], ry[1]);
         end
      end
      @(negedge clk);
      total++;
      if ({op_count, busy} !== {16'h0005, 1'b0}) begin
         bad++;
         $display("FAIL b2b_count got cnt=%h busy=%b want 0005 0", op_count, busy);
      end
   endtask

   task automatic test_latency();
      logic [15:0] c;
      c = cyc;
      lv = 1'b1;
      @(negedge clk);
      lv = 1'b0;
      total++;
      if ({busy0, rsp_valid0, busy15, rsp_valid15} !== 4'b1010) begin
         bad++;
         $display("FAIL lat_accept got %b%b%b%b want 1010", busy0, rsp_valid0, busy15, rsp_valid15);
      end
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         if (k == 1) begin
            total++;
            if ({rsp_valid0, rsp_y0} !== {1'b1, c + 16'd1}) begin
               bad++;
               $display("FAIL lat0_capture got valid=%b y=%h want 1 %h", rsp_valid0, rsp_y0, c + 16'd1);
            end
         end
         if (k == 15) begin
            total++;
            if (rsp_valid15 !== 1'b0) begin
               bad++;
               $display("FAIL lat15_early got %b want 0", rsp_valid15);
            end
         end
      end
      total++;
      if ({rsp_valid15, rsp_y15, rsp_valid0, rsp_y0} !== {1'b1, c + 16'd16, 1'b1, c + 16'd1}) begin
         bad++;
         $display("FAIL lat15_capture got valid=%b y=%h (lat0 %b %h) want 1 %h (1 %h)",
                  rsp_valid15, rsp_y15, rsp_valid0, rsp_y0, c + 16'd16, c + 16'd1);
      end
      lr = 1'b1;
      @(negedge clk);
      lr = 1'b0;
      total++;
      if ({op_count0, op_count15, busy0, busy15} !== {16'h0001, 16'h0001, 2'b00}) begin
         bad++;
         $display("FAIL lat_handshake got %h %h busy=%b%b want 0001 0001 00", op_count0, op_count15, busy0, busy15);
      end
   endtask

   task automatic test_reset_mid();
      cmd_a = 16'h0009; cmd_b = 16'h0001; cmd_op = 2'b10; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      total++;
      if ({cmd_ready, busy, rsp_valid, rsp_zero, alu_a, alu_b, alu_op, rsp_y, rsp_op, op_count} !== '0) begin
         bad++;
         $display("FAIL async_reset got ready=%b busy=%b valid=%b a=%h y=%h cnt=%h want all zero",
                  cmd_ready, busy, rsp_valid, alu_a, rsp_y, op_count);
      end
      @(negedge clk);
      reset = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if ({rsp_valid, busy, op_count} !== {2'b00, 16'h0000}) begin
            bad++;
            $display("FAIL post_reset[%0d] got valid=%b busy=%b cnt=%h want 0 0 0000", k, rsp_valid, busy, op_count);
         end
      end
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_opcodes();
      test_latency();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
